comparator_response_checker: RTL and testbench
==============================================

// Module: comparator_response_checker
// PURPOSE
//  Hardware-side stimulus/response engine for the one-bit comparator: drives
//  A/B through all four vectors {00,01,10,11} and samples o1/o2/o3.
//  Compares each sample against the golden model and counts mismatches.
//  Sits beside the comparator in an FPGA self-test wrapper; reports pass/fail
//  without a simulator.
//  Golden model: o1 = (A<B), o2 = (A==B), o3 = (A>B).
// PARAMETERS
//  SETTLE_CYCLES  2  cycles between driving a vector and sampling; legal >=1
//  PASSES         1  full sweeps of the 4 vectors per run; legal >=1
//  ERR_W          8  width of mismatch counter (saturating)
// PORTS
//  clk        in   1      single clock; all logic on rising edge
//  rst        in   1      synchronous, active-high reset
//  start      in   1      run request; sampled only in IDLE
//  dut_a      out  1      A to comparator
//  dut_b      out  1      B to comparator
//  dut_o1     in   1      comparator o1 (A<B)
//  dut_o2     in   1      comparator o2 (A==B)
//  dut_o3     in   1      comparator o3 (A>B)
//  busy       out  1      high from cycle after accepted start until DONE
//  done       out  1      high in DONE; held until next accepted start
//  pass       out  1      valid when done; 1 iff err_count==0
//  err_count  out  ERR_W  mismatches this run, saturates at 2^ERR_W-1
//  vec_idx    out  2      current vector {A,B}; also drives dut_a/dut_b
// BEHAVIOUR
//  Reset (rst=1 at clk edge, any state, incl. mid-run): state=IDLE.
//   dut_a=dut_b=0, busy=0, done=0, pass=0, err_count=0, vec_idx=0,
//   settle and pass counters=0. Effective on the next edge; no partial result.
//  FSM states and transitions:
//   IDLE  : start=1 -> DRIVE; clears err_count/done/pass, vec_idx=0, pass cnt=0.
//   DRIVE : registers dut_a,dut_b = vec_idx[1],vec_idx[0]; settle cnt=1 -> SETTLE.
//   SETTLE: increments cnt; when cnt==SETTLE_CYCLES -> SAMPLE.
//   SAMPLE: mismatch if {o1,o2,o3} != golden(vec_idx); err_count+=1 unless
//           saturated. Then -> NEXT.
//   NEXT  : vec_idx==3 and last pass -> DONE. vec_idx==3 otherwise: vec_idx
//           wraps 3->0, pass cnt+=1, -> DRIVE. Else vec_idx+=1 -> DRIVE.
//   DONE  : done=1, pass=(err_count==0); start=1 -> behaves as IDLE accept.
//  Per-vector latency: 1 (DRIVE) + SETTLE_CYCLES + 1 (SAMPLE) + 1 (NEXT)
//   = SETTLE_CYCLES+3 cycles.
//  Run length: start edge + PASSES*4*(SETTLE_CYCLES+3) cycles to DONE.
//  start while busy: ignored, no restart.
//  start and rst in the same cycle: rst wins.
//  Outputs must be X-free: any X on dut_o* counts as a mismatch.
//  dut_a/dut_b are stable from DRIVE through NEXT of each vector.
// CONFIGURATION
//  CMP_CHECK_LOG_EN defined: adds ports
//   fail_valid  out  1   first mismatch captured this run
//   fail_vec    out  2   {A,B} of first mismatch
//   fail_obs    out  3   observed {o1,o2,o3} of first mismatch
//   All three are reset to 0, cleared on accepted start, and written once per
//   run (first mismatch only).
//  CMP_CHECK_LOG_EN undefined: ports and capture registers absent; all else
//   identical.
// TESTING
//  T1 correct comparator, SETTLE=2, PASSES=1, start pulse -> done after 20
//     cycles; pass=1; err_count=0; dut_a/b sequence 00,01,10,11.
//  T2 dut_o2 forced 0 -> vectors 00 and 11 fail; err_count=2, pass=0;
//     with LOG_EN: fail_vec=00, fail_obs=000.
//  T3 o1/o3 swapped, PASSES=3 -> err_count=6; ERR_W=2 -> saturates at 3.
//  T4 rst=1 during SETTLE of vector 10 -> next edge: all outputs 0, state IDLE;
//     new start -> full clean run, pass=1.
//  T5 start held high through run -> single run only; restart from DONE with
//     start=1 -> err_count cleared, second run completes identically.
//  T6 SETTLE_CYCLES=1 -> per-vector period 4 cycles; done after 16 cycles.

Source files
------------

// File: rtl/comparator_response_checker.sv
// Self-test engine for a one-bit comparator: sweeps {A,B} through 00..11, samples o1/o2/o3
// against the golden relations and counts mismatches. Optional first-failure log: CMP_CHECK_LOG_EN.
module comparator_response_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             dut_a,
  output logic             dut_b,
  input  logic             dut_o1,
  input  logic             dut_o2,
  input  logic             dut_o3,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       vec_idx
`ifdef CMP_CHECK_LOG_EN
  ,
  output logic             fail_valid,
  output logic [1:0]       fail_vec,
  output logic [2:0]       fail_obs
`endif
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int PW = $clog2(PASSES + 1);
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES);
  localparam logic [PW-1:0]    PASS_LAST   = PW'(PASSES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, NEXT, DONE} state_t;

  state_t        state, state_next;
  logic [SW-1:0] settle_cnt;
  logic [PW-1:0] pass_cnt;
  logic          accept;
  logic [2:0]    golden;
  logic [2:0]    observed;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        accept = start;
        if (start) state_next = DRIVE;
      end
      DRIVE: begin
        busy       = 1'b1;
        state_next = SETTLE;
      end
      SETTLE: begin
        busy = 1'b1;
        if (settle_cnt == SETTLE_LAST) state_next = SAMPLE;
      end
      SAMPLE: begin
        busy       = 1'b1;
        state_next = NEXT;
      end
      NEXT: begin
        busy = 1'b1;
        if (vec_idx == 2'd3 && pass_cnt == PASS_LAST) state_next = DONE;
        else                                          state_next = DRIVE;
      end
      DONE: begin
        done   = 1'b1;
        accept = start;
        if (start) state_next = DRIVE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign pass     = done && (err_count == '0);
  assign golden   = {~vec_idx[1] & vec_idx[0], ~(vec_idx[1] ^ vec_idx[0]), vec_idx[1] & ~vec_idx[0]};
  assign observed = {dut_o1, dut_o2, dut_o3};

  // dut_a/dut_b are reloaded whenever vec_idx changes, so A/B already hold the
  // new vector during DRIVE and stay put until NEXT.
  always_ff @(posedge clk) begin
    if (rst) begin
      dut_a      <= 1'b0;
      dut_b      <= 1'b0;
      err_count  <= '0;
      vec_idx    <= 2'd0;
      settle_cnt <= '0;
      pass_cnt   <= '0;
`ifdef CMP_CHECK_LOG_EN
      fail_valid <= 1'b0;
      fail_vec   <= 2'd0;
      fail_obs   <= 3'd0;
`endif
    end else if (accept) begin
      dut_a      <= 1'b0;
      dut_b      <= 1'b0;
      err_count  <= '0;
      vec_idx    <= 2'd0;
      settle_cnt <= '0;
      pass_cnt   <= '0;
`ifdef CMP_CHECK_LOG_EN
      fail_valid <= 1'b0;
      fail_vec   <= 2'd0;
      fail_obs   <= 3'd0;
`endif
    end else begin
      case (state)
        DRIVE: begin
          dut_a      <= vec_idx[1];
          dut_b      <= vec_idx[0];
          settle_cnt <= SW'(1);
        end
        SETTLE: begin
          if (settle_cnt != SETTLE_LAST) settle_cnt <= settle_cnt + SW'(1);
        end
        SAMPLE: begin
          // Mismatch lives in the else branch so an unknown compare also counts.
          if (observed == golden) begin
            err_count <= err_count;
          end else begin
            if (err_count != ERR_MAX) err_count <= err_count + ERR_W'(1);
`ifdef CMP_CHECK_LOG_EN
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_vec   <= vec_idx;
              fail_obs   <= observed;
            end
`endif
          end
        end
        NEXT: begin
          if (vec_idx == 2'd3) begin
            if (pass_cnt != PASS_LAST) begin
              vec_idx  <= 2'd0;
              dut_a    <= 1'b0;
              dut_b    <= 1'b0;
              pass_cnt <= pass_cnt + PW'(1);
            end
          end else begin
            vec_idx        <= vec_idx + 2'd1;
            {dut_a, dut_b} <= vec_idx + 2'd1;
          end
        end
        default: begin
          settle_cnt <= settle_cnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_response_checker.sv
// Bench for comparator_response_checker: two instances (default and SETTLE=1/PASSES=3/ERR_W=2)
// each driving a fault-injectable comparator model; results checked against an arithmetic reference.
module tb_comparator_response_checker;

  localparam int S0 = 2, P0 = 1, E0 = 8;
  localparam int S1 = 1, P1 = 3, E1 = 2;

  logic clk, rst, start0, start1;
  logic a0, b0, o1_0, o2_0, o3_0, busy0, done0, pass0;
  logic a1, b1, o1_1, o2_1, o3_1, busy1, done1, pass1;
  logic [E0-1:0] err0;
  logic [E1-1:0] err1;
  logic [1:0] vec0, vec1;
  logic [11:0] mask0, mask1;
`ifdef CMP_CHECK_LOG_EN
  logic fv0, fv1;
  logic [1:0] fvec0, fvec1;
  logic [2:0] fobs0, fobs1;
`endif

  int checks = 0;
  int failures = 0;
  int done_at0, done_at1;

  comparator_response_checker #(.SETTLE_CYCLES(S0), .PASSES(P0), .ERR_W(E0)) u_chk0 (
    .clk(clk), .rst(rst), .start(start0), .dut_a(a0), .dut_b(b0),
    .dut_o1(o1_0), .dut_o2(o2_0), .dut_o3(o3_0), .busy(busy0), .done(done0),
    .pass(pass0), .err_count(err0), .vec_idx(vec0)
`ifdef CMP_CHECK_LOG_EN
    , .fail_valid(fv0), .fail_vec(fvec0), .fail_obs(fobs0)
`endif
  );

  comparator_response_checker #(.SETTLE_CYCLES(S1), .PASSES(P1), .ERR_W(E1)) u_chk1 (
    .clk(clk), .rst(rst), .start(start1), .dut_a(a1), .dut_b(b1),
    .dut_o1(o1_1), .dut_o2(o2_1), .dut_o3(o3_1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(err1), .vec_idx(vec1)
`ifdef CMP_CHECK_LOG_EN
    , .fail_valid(fv1), .fail_vec(fvec1), .fail_obs(fobs1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] golden_of(input logic a, input logic b);
    return {(a < b), (a == b), (a > b)};
  endfunction

  function automatic logic [2:0] mask_of(input logic [11:0] m, input logic [1:0] v);
    int idx;
    idx = int'(v);
    return m[idx*3 +: 3];
  endfunction

  // Comparator stand-ins: the golden relation with per-vector bit flips injected.
  always_comb {o1_0, o2_0, o3_0} = golden_of(a0, b0) ^ mask_of(mask0, {a0, b0});
  always_comb {o1_1, o2_1, o3_1} = golden_of(a1, b1) ^ mask_of(mask1, {a1, b1});

  function automatic int expect_err(input logic [11:0] m, input int passes, input int err_w);
    int bad, total, max_val;
    bad = 0;
    for (int v = 0; v < 4; v++) if (mask_of(m, 2'(v)) != 3'd0) bad++;
    total   = bad * passes;
    max_val = (1 << err_w) - 1;
    return (total > max_val) ? max_val : total;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expected);
    checks++;
    assert (obs === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expected);
    end
  endtask

  task automatic check_idle(input string tag);
    checkOutput({tag, "_a0"}, a0, 0);
    checkOutput({tag, "_b0"}, b0, 0);
    checkOutput({tag, "_busy0"}, busy0, 0);
    checkOutput({tag, "_done0"}, done0, 0);
    checkOutput({tag, "_pass0"}, pass0, 0);
    checkOutput({tag, "_err0"}, err0, 0);
    checkOutput({tag, "_vec0"}, vec0, 0);
    checkOutput({tag, "_busy1"}, busy1, 0);
    checkOutput({tag, "_err1"}, err1, 0);
`ifdef CMP_CHECK_LOG_EN
    checkOutput({tag, "_fv0"}, fv0, 0);
`endif
  endtask

  // Starts both checkers, follows them interval by interval until each reports done.
  task automatic applyStimulus(input bit hold0, input bit hold1, input int gap);
    repeat (gap) @(negedge clk);
    start0 = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    done_at0 = -1;
    done_at1 = -1;
    for (int j = 0; j < 400 && (done_at0 < 0 || done_at1 < 0); j++) begin
      if (j == 0) begin
        checkOutput("err_cleared0", err0, 0);
        checkOutput("err_cleared1", err1, 0);
        checkOutput("done_cleared0", done0, 0);
      end
      if (done_at0 < 0) begin
        if (done0) begin
          done_at0 = j;
          start0 = 1'b0;
        end else begin
          checkOutput("busy0", busy0, 1);
          checkOutput("ab0", {a0, b0}, (j / (S0 + 3)) % 4);
          checkOutput("vec_idx0", vec0, (j / (S0 + 3)) % 4);
        end
      end
      if (done_at1 < 0) begin
        if (done1) begin
          done_at1 = j;
          start1 = 1'b0;
        end else begin
          checkOutput("busy1", busy1, 1);
          checkOutput("ab1", {a1, b1}, (j / (S1 + 3)) % 4);
        end
      end
      if (j == 0) begin
        if (!hold0) start0 = 1'b0;
        if (!hold1) start1 = 1'b0;
      end
      @(negedge clk);
    end
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic check_run(input string tag);
    int e0, e1;
    e0 = expect_err(mask0, P0, E0);
    e1 = expect_err(mask1, P1, E1);
    checkOutput({tag, "_len0"}, done_at0, P0 * 4 * (S0 + 3));
    checkOutput({tag, "_len1"}, done_at1, P1 * 4 * (S1 + 3));
    checkOutput({tag, "_err0"}, err0, e0);
    checkOutput({tag, "_err1"}, err1, e1);
    checkOutput({tag, "_pass0"}, pass0, (e0 == 0));
    checkOutput({tag, "_pass1"}, pass1, (e1 == 0));
`ifdef CMP_CHECK_LOG_EN
    begin
      int first;
      first = -1;
      for (int v = 3; v >= 0; v--) if (mask_of(mask0, 2'(v)) != 3'd0) first = v;
      checkOutput({tag, "_fv0"}, fv0, (first >= 0));
      if (first >= 0) begin
        checkOutput({tag, "_fvec0"}, fvec0, first);
        checkOutput({tag, "_fobs0"}, fobs0,
                    golden_of(first[1], first[0]) ^ mask_of(mask0, 2'(first)));
      end
    end
`endif
    repeat (2) @(negedge clk);
    checkOutput({tag, "_hold_done0"}, done0, 1);
    checkOutput({tag, "_hold_busy0"}, busy0, 0);
    checkOutput({tag, "_hold_done1"}, done1, 1);
    checkOutput({tag, "_hold_err1"}, err1, e1);
  endtask

  initial begin
    rst = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    mask0 = '0;
    mask1 = '0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] clean sweep");
    applyStimulus(1'b0, 1'b0, 0);
    check_run("clean");

    $display("[TB] o2 stuck low / o1,o3 swapped");
    mask0 = {3'b010, 3'b000, 3'b000, 3'b010};
    mask1 = {3'b000, 3'b101, 3'b101, 3'b000};
    applyStimulus(1'b0, 1'b0, 1);
    check_run("faults");

    $display("[TB] start held, then restart from done");
    mask0 = {3'b000, 3'b101, 3'b101, 3'b000};
    mask1 = {3'b001, 3'b000, 3'b000, 3'b000};
    applyStimulus(1'b1, 1'b1, 0);
    check_run("hold");
    applyStimulus(1'b1, 1'b0, 0);
    check_run("restart");

    $display("[TB] randomized fault patterns");
    for (int r = 0; r < 5; r++) begin
      mask0 = 12'($urandom);
      mask1 = 12'($urandom);
      if (r == 0) mask0 = '0;
      applyStimulus(1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
      check_run("random");
    end

    $display("[TB] reset during settle of vector 10");
    mask0 = {3'b000, 3'b000, 3'b000, 3'b010};
    mask1 = {3'b000, 3'b000, 3'b000, 3'b010};
    @(negedge clk);
    start0 = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    repeat (2 * (S0 + 3) + 1) @(negedge clk);
    checkOutput("pre_reset_vec0", vec0, 2);
    checkOutput("pre_reset_err0", err0, 1);
    checkOutput("pre_reset_busy0", busy0, 1);
    rst = 1'b1;
    start0 = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    check_idle("midrun_reset");
    rst = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_busy0", busy0, 0);
    mask0 = '0;
    mask1 = '0;
    applyStimulus(1'b0, 1'b0, 0);
    check_run("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
